// File: rtl/step_run_ctrl.sv
// Run/step control receiver: synchronises run, debounces step, and produces a CPU clock-enable.
// Optional auto-repeat while the step button is held is compiled in with `define STEP_AUTOREPEAT_EN.
module step_run_ctrl #(
   parameter int DB_CYCLES     = 1000000,
   parameter int CNT_W         = 16,
   parameter int REPEAT_CYCLES = 50000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             step,
   output logic             cpu_en,
   output logic             step_pulse,
   output logic             step_stable,
   output logic [CNT_W-1:0] step_count
);

   localparam int             DBW     = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

   if (DB_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
      $error("step_run_ctrl: DB_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
   end

   logic             run_s1_q, run_s2_q;
   logic             step_s1_q, step_s2_q;
   logic [DBW-1:0]   db_cnt_q, db_cnt_d;
   logic             stable_q, stable_d;
   logic             stable_dly_q;
   logic             pulse_q, en_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rise, press, fire;

   // Stage 1: two-flop synchronisers, debounce, and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         run_s1_q     <= 1'b0;
         run_s2_q     <= 1'b0;
         step_s1_q    <= 1'b0;
         step_s2_q    <= 1'b0;
         db_cnt_q     <= '0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         pulse_q      <= 1'b0;
         en_q         <= 1'b0;
         cnt_q        <= '0;
      end else begin
         run_s1_q     <= run;
         run_s2_q     <= run_s1_q;
         step_s1_q    <= step;
         step_s2_q    <= step_s1_q;
         db_cnt_q     <= db_cnt_d;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         pulse_q      <= fire;
         en_q         <= run_s2_q | fire;
         cnt_q        <= cnt_d;
      end
   end

   // Any sample that agrees with the accepted level restarts the stability count.
   always_comb begin
      db_cnt_d = db_cnt_q;
      stable_d = stable_q;
      if (step_s2_q == stable_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         stable_d = step_s2_q;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + {{(DBW-1){1'b0}}, 1'b1};
      end
   end

   assign rise  = stable_q & ~stable_dly_q;
   assign press = rise & ~run_s2_q;

`ifdef STEP_AUTOREPEAT_EN
   localparam int            HW       = $clog2(REPEAT_CYCLES + 1);
   localparam logic [HW-1:0] RPT_LAST = HW'(REPEAT_CYCLES - 1);

   logic [HW-1:0] hold_q, hold_d;
   logic          rpt;

   // Hold counter measures cycles since the last issued pulse while the button is held
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   always_comb begin
      rpt    = 1'b0;
      hold_d = hold_q + {{(HW-1){1'b0}}, 1'b1};
      if (!stable_q || run_s2_q) begin
         hold_d = '0;
      end else if (rise) begin
         hold_d = '0;
      end else if (hold_q == RPT_LAST) begin
         rpt    = 1'b1;
         hold_d = '0;
      end
   end

   assign fire = press | rpt;
`else
   assign fire = press;
`endif

   assign cnt_d = fire ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

   assign cpu_en      = en_q;
   assign step_pulse  = pulse_q;
   assign step_stable = stable_q;
   assign step_count  = cnt_q;

endmodule

// File: tb/tb_step_run_ctrl.sv
// Self-checking bench for step_run_ctrl: directed scenarios plus random stimulus against a window-based model.
module tb_step_run_ctrl;

   localparam int DB  = 4;
   localparam int RPT = 10;
   localparam int CW  = 16;
   localparam int CWS = 3;
`ifdef STEP_AUTOREPEAT_EN
   localparam int PRESS_EXP = 3;
   localparam int HOLD_EXP  = 4;
`else
   localparam int PRESS_EXP = 1;
   localparam int HOLD_EXP  = 1;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic run = 1'b0;
   logic step = 1'b0;
   logic cpu_en, step_pulse, step_stable;
   logic [CW-1:0] step_count;
   logic w_cpu_en, w_step_pulse, w_step_stable;
   logic [CWS-1:0] w_step_count;

   int errors = 0;
   int checks = 0;
   int pulses_seen = 0;

   // Reference model state
   bit sh [0:DB];
   bit rh [0:1];
   bit stab_a, stab_b;
   bit m_pulse, m_en;
   int unsigned m_cnt;
   int m_since;

   step_run_ctrl #(.DB_CYCLES(DB), .CNT_W(CW), .REPEAT_CYCLES(RPT)) dut (
      .clk(clk), .reset(reset), .run(run), .step(step),
      .cpu_en(cpu_en), .step_pulse(step_pulse), .step_stable(step_stable), .step_count(step_count));

   step_run_ctrl #(.DB_CYCLES(DB), .CNT_W(CWS), .REPEAT_CYCLES(RPT)) dut_w (
      .clk(clk), .reset(reset), .run(run), .step(step),
      .cpu_en(w_cpu_en), .step_pulse(w_step_pulse), .step_stable(w_step_stable), .step_count(w_step_count));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // The accepted level flips once the last DB synchronised samples all disagree with it.
   task automatic model_edge();
      bit run_now, rise, rpt, fire, all_diff;
      if (reset) begin
         for (int k = 0; k <= DB; k++) sh[k] = 1'b0;
         rh[0] = 1'b0; rh[1] = 1'b0;
         stab_a = 1'b0; stab_b = 1'b0;
         m_pulse = 1'b0; m_en = 1'b0; m_cnt = 0; m_since = 0;
      end else begin
         run_now = rh[1];
         rise    = stab_a & ~stab_b;
         rpt     = 1'b0;
`ifdef STEP_AUTOREPEAT_EN
         if (!(stab_a && !run_now)) m_since = 0;
         else if (rise) m_since = 0;
         else if (m_since == RPT - 1) begin rpt = 1'b1; m_since = 0; end
         else m_since++;
`endif
         fire    = (rise & ~run_now) | rpt;
         m_pulse = fire;
         m_en    = run_now | fire;
         if (fire) m_cnt++;
         all_diff = 1'b1;
         for (int k = 1; k <= DB; k++) if (sh[k] == stab_a) all_diff = 1'b0;
         stab_b = stab_a;
         if (all_diff) stab_a = ~stab_a;
         for (int k = DB; k > 0; k--) sh[k] = sh[k-1];
         sh[0] = step;
         rh[1] = rh[0];
         rh[0] = run;
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         if (step_pulse === 1'b1) pulses_seen++;
         chk("cyc_cpu_en", {31'b0, cpu_en}, {31'b0, m_en});
         chk("cyc_step_pulse", {31'b0, step_pulse}, {31'b0, m_pulse});
         chk("cyc_step_stable", {31'b0, step_stable}, {31'b0, stab_a});
         chk("cyc_step_count", {16'b0, step_count}, m_cnt % (1 << CW));
         chk("cyc_wrap_count", {29'b0, w_step_count}, m_cnt % (1 << CWS));
      end
   endtask

   initial begin
      logic [CW-1:0] base, diff;
      int n_wrap;

      // Reset and idle
      reset = 1'b1; run = 1'b0; step = 1'b0;
      cyc(3);
      chk("reset_cpu_en", {31'b0, cpu_en}, 0);
      chk("reset_pulse", {31'b0, step_pulse}, 0);
      chk("reset_stable", {31'b0, step_stable}, 0);
      chk("reset_count", {16'b0, step_count}, 0);
      reset = 1'b0;
      cyc(20);
      chk("idle_pulses", pulses_seen, 0);

      // Single clean press held 30 cycles
      step = 1'b1;
      cyc(30);
      chk("press_stable", {31'b0, step_stable}, 1);
      chk("press_count", {16'b0, step_count}, PRESS_EXP);
      chk("press_pulses", pulses_seen, PRESS_EXP);
      step = 1'b0;
      cyc(12);

      // Bounce shorter than the debounce window
      pulses_seen = 0;
      for (int r = 0; r < 2; r++) begin
         step = 1'b1; cyc(2);
         step = 1'b0; cyc(2);
      end
      cyc(10);
      chk("bounce_pulses", pulses_seen, 0);
      chk("bounce_count", {16'b0, step_count}, PRESS_EXP);

      // Run mode: latency and consumed press
      run = 1'b1;
      cyc(2);
      chk("run_lat_early", {31'b0, cpu_en}, 0);
      cyc(1);
      chk("run_lat_on", {31'b0, cpu_en}, 1);
      pulses_seen = 0;
      step = 1'b1; cyc(15);
      step = 1'b0; cyc(10);
      chk("run_pulses", pulses_seen, 0);
      chk("run_count", {16'b0, step_count}, PRESS_EXP);
      run = 1'b0;
      cyc(2);
      chk("run_off_early", {31'b0, cpu_en}, 1);
      cyc(1);
      chk("run_off", {31'b0, cpu_en}, 0);

      // run_s2 rises in the same cycle as the debounced rise
      step = 1'b1; cyc(4);
      run = 1'b1; cyc(3);
      chk("simul_pulse", {31'b0, step_pulse}, 0);
      chk("simul_en", {31'b0, cpu_en}, 1);
      cyc(10);
      step = 1'b0; cyc(10);
      run = 1'b0; cyc(5);
      chk("simul_count", {16'b0, step_count}, PRESS_EXP);

      // Wrap of the narrow counter instance
      n_wrap = (1 << CWS) - PRESS_EXP;
      for (int p = 0; p < n_wrap - 1; p++) begin
         step = 1'b1; cyc(8);
         step = 1'b0; cyc(8);
      end
      step = 1'b1; cyc(7);
      chk("wrap_pulse", {31'b0, w_step_pulse}, 1);
      chk("wrap_count", {29'b0, w_step_count}, 0);
      cyc(1);
      step = 1'b0; cyc(8);
      chk("wrap_main_count", {16'b0, step_count}, 1 << CWS);

      // Long hold: single pulse, or auto-repeat when compiled in
      base = step_count;
      step = 1'b1; cyc(36);
      step = 1'b0; cyc(12);
      diff = step_count - base;
      chk("hold_count", {16'b0, diff}, HOLD_EXP);

      // Button held through reset release counts as a new press
      step = 1'b1; cyc(3);
      reset = 1'b1; cyc(2);
      reset = 1'b0;
      pulses_seen = 0;
      cyc(5);
      chk("rst_held_early", pulses_seen, 0);
      cyc(2);
      chk("rst_held_pulse", {31'b0, step_pulse}, 1);
      chk("rst_held_count", {16'b0, step_count}, 1);
      step = 1'b0; cyc(10);

      // Random segments of step/run activity with occasional reset
      for (int s = 0; s < 80; s++) begin
         step = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) run = ~run;
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b1; cyc(1); reset = 1'b0;
         end
         cyc($urandom_range(1, 12));
      end
      run = 1'b0; step = 1'b0;
      cyc(15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
